rv_ma_lsu: RTL

RV_MA_LSU -- requirements
Module: rv_ma_lsu

---
 rtl/rv_ma_lsu_if.sv | 48 ++++
 rtl/rv_ma_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rv_ma_lsu_if.sv
// rv_ma_lsu_if -- data-memory request/response bus used by the load/store unit.
//
// Signals:
//   dmem_req_valid    request offered (held stable until dmem_req_ready)
//   dmem_req_ready    memory accepts the request this cycle
//   dmem_req_wr_en    1 = store, 0 = load
//   dmem_req_addr     XLEN  aligned address (low log2(BE_W) bits zero)
//   dmem_req_byte_en  BE_W  active byte lanes
//   dmem_req_wr_data  XLEN  store data already shifted into its lanes
//   dmem_rsp_valid    load response present
//   dmem_rsp_data     XLEN  full aligned word returned by memory
//
// Modports: master (LSU side), slave (memory side).
interface rv_ma_lsu_if #(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
);
   logic            dmem_req_valid;
   logic            dmem_req_ready;
   logic            dmem_req_wr_en;
   logic [XLEN-1:0] dmem_req_addr;
   logic [BE_W-1:0] dmem_req_byte_en;
   logic [XLEN-1:0] dmem_req_wr_data;
   logic            dmem_rsp_valid;
   logic [XLEN-1:0] dmem_rsp_data;

   modport master (
      output dmem_req_valid,
      output dmem_req_wr_en,
      output dmem_req_addr,
      output dmem_req_byte_en,
      output dmem_req_wr_data,
      input  dmem_req_ready,
      input  dmem_rsp_valid,
      input  dmem_rsp_data
   );

   modport slave (
      input  dmem_req_valid,
      input  dmem_req_wr_en,
      input  dmem_req_addr,
      input  dmem_req_byte_en,
      input  dmem_req_wr_data,
      output dmem_req_ready,
      output dmem_rsp_valid,
      output dmem_rsp_data
   );
endinterface

// File: rtl/rv_ma_lsu.sv
// rv_ma_lsu -- load/store unit sitting between pipeline stages Q103H and Q104H.
//
// Takes a decoded instruction in Q103H, issues at most one data-memory request
// at a time, formats load data, and registers the write-back result into Q104H.
// Misaligned accesses are not sent to memory; they retire at once with the
// misalign flag set.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_Q103H                 instruction present
//   rd_en_Q103H / wr_en_Q103H   load / store
//   size_Q103H                  00 byte, 01 half, 10 word, 11 double
//   sign_ext_Q103H              sign-extend load result
//   sel_wb_Q103H                00 pc_plus4, 01 alu_out, 10 load data, 11 zero
//   pc_plus4_Q103H, alu_out_Q103H (byte address), wr_data_Q103H
//   stall_Q103H                 upstream must hold Q103H inputs
//   bus                         data-memory interface (master side)
//   wb_valid_Q104H, wb_data_Q104H, misalign_Q104H   registered write-back
module rv_ma_lsu #(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_Q103H,
   input  logic            rd_en_Q103H,
   input  logic            wr_en_Q103H,
   input  logic [1:0]      size_Q103H,
   input  logic            sign_ext_Q103H,
   input  logic [1:0]      sel_wb_Q103H,
   input  logic [XLEN-1:0] pc_plus4_Q103H,
   input  logic [XLEN-1:0] alu_out_Q103H,
   input  logic [XLEN-1:0] wr_data_Q103H,
   output logic            stall_Q103H,
   rv_ma_lsu_if.master     bus,
   output logic            wb_valid_Q104H,
   output logic [XLEN-1:0] wb_data_Q104H,
   output logic            misalign_Q104H
);
   localparam int OFF_W = $clog2(BE_W);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state_reg, state_next;
   logic            mem_op;
   logic            misaligned;
   logic            complete;
   logic            req_valid;
   logic [OFF_W-1:0] offset;
   logic [7:0]      be_base;
   logic [XLEN-1:0] rsp_shifted;
   logic [XLEN-1:0] load_mask;
   logic            load_sign;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_sel_data;

   logic            wb_valid_reg;
   logic [XLEN-1:0] wb_data_reg;
   logic            misalign_reg;

   assign mem_op = valid_Q103H & (rd_en_Q103H | wr_en_Q103H);
   assign offset = alu_out_Q103H[OFF_W-1:0];

   // Doubleword accesses do not exist on a 32-bit datapath, so they are
   // reported as misaligned rather than split into two requests.
   always_comb begin
      misaligned = 1'b0;
      case (size_Q103H)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = alu_out_Q103H[0];
         2'b10:   misaligned = |alu_out_Q103H[1:0];
         default: misaligned = (XLEN == 32) ? 1'b1 : |alu_out_Q103H[2:0];
      endcase
   end

   // Request fields are pure functions of the Q103H inputs; because the
   // pipeline holds those inputs while stalled, the request stays stable
   // for as long as it is offered.
   always_comb begin
      be_base = 8'h01;
      case (size_Q103H)
         2'b00:   be_base = 8'h01;
         2'b01:   be_base = 8'h03;
         2'b10:   be_base = 8'h0F;
         default: be_base = 8'hFF;
      endcase
   end

   assign bus.dmem_req_valid   = req_valid;
   assign bus.dmem_req_wr_en   = wr_en_Q103H;
   assign bus.dmem_req_addr    = {alu_out_Q103H[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign bus.dmem_req_byte_en = BE_W'(be_base) << offset;
   assign bus.dmem_req_wr_data = wr_data_Q103H << {offset, 3'b000};

   // Load formatting: bring the addressed bytes down to bit 0, keep the
   // access width via a mask, then fill the upper bits with the sign or zero.
   assign rsp_shifted = bus.dmem_rsp_data >> {offset, 3'b000};
   assign load_mask   = ~({XLEN{1'b1}} << (8 << size_Q103H));

   always_comb begin
      load_sign = rsp_shifted[XLEN-1];
      case (size_Q103H)
         2'b00:   load_sign = rsp_shifted[7];
         2'b01:   load_sign = rsp_shifted[15];
         2'b10:   load_sign = rsp_shifted[31];
         default: load_sign = rsp_shifted[XLEN-1];
      endcase
   end

   assign load_data = (rsp_shifted & load_mask) |
                      ((sign_ext_Q103H & load_sign) ? ~load_mask : {XLEN{1'b0}});

   // Next-state and handshake decode.
   always_comb begin
      state_next = state_reg;
      req_valid  = 1'b0;
      complete   = 1'b0;
      case (state_reg)
         IDLE, REQ: begin
            if (!mem_op) begin
               state_next = IDLE;
            end else if (misaligned) begin
               complete   = 1'b1;
               state_next = IDLE;
            end else begin
               req_valid = 1'b1;
               if (bus.dmem_req_ready) begin
                  if (wr_en_Q103H) begin
                     complete   = 1'b1;
                     state_next = IDLE;
                  end else begin
                     state_next = WAIT;
                  end
               end else begin
                  state_next = REQ;
               end
            end
         end
         WAIT: begin
            // Responses are only meaningful here; anywhere else they are stale.
            if (bus.dmem_rsp_valid) begin
               complete   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         state_next = IDLE;
         req_valid  = 1'b0;
      end
   end

   assign stall_Q103H = mem_op & ~complete & ~rst;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      wb_sel_data = {XLEN{1'b0}};
      case (sel_wb_Q103H)
         2'b00:   wb_sel_data = pc_plus4_Q103H;
         2'b01:   wb_sel_data = alu_out_Q103H;
         2'b10:   wb_sel_data = load_data;
         default: wb_sel_data = {XLEN{1'b0}};
      endcase
   end

   // While stalled the data register holds and a bubble enters Q104H.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_reg <= 1'b0;
         wb_data_reg  <= {XLEN{1'b0}};
         misalign_reg <= 1'b0;
      end else if (stall_Q103H) begin
         wb_valid_reg <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         wb_valid_reg <= valid_Q103H;
         misalign_reg <= mem_op & misaligned;
         wb_data_reg  <= (mem_op & misaligned) ? {XLEN{1'b0}} : wb_sel_data;
      end
   end

   assign wb_valid_Q104H = wb_valid_reg;
   assign wb_data_Q104H  = wb_data_reg;
   assign misalign_Q104H = misalign_reg;
endmodule
